mux_arbiter8: RTL
=================

# mux_arbiter8

Round-robin arbiter and sequencer for an 8-source, 32-bit shared datapath. Eight requesters compete for one output bus. The block grants one requester at a time and drives the 3-bit select of its internal 8:1 32-bit multiplexer. It registers the selected word onto the output with a valid flag. A per-grant hold limit prevents any requester from starving the others. It sits between the per-source producers (display/peripheral data sources) and the single consumer on the board.

## Interface
- HOLD_MAX, 16, maximum consecutive cycles one grant may last; legal range 1..255.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request per source; bit k high = source k wants the bus.
- din0..din7  input  32 each  source data words.
- grant  output  8  one-hot grant, all-zero when idle.
- sel  output  3  current/last granted index (mux select).
- dout  output  32  registered mux output.
- dout_valid  output  1  dout carries data of a granted source.
- tmo  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.
- busy  output  1  high while in BUSY state.

## Operation
- Reset values: grant=0, sel=0, dout=0, dout_valid=0, tmo=0, busy=0. Internal ptr=0, cnt=0, state=IDLE.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise choose k = first set bit of req searching ptr, ptr+1, …, ptr+7 (mod 8).
  - On the edge, set grant=1<<k, sel=k, cnt=1, and move to BUSY.
- State BUSY (granted index g=sel):
  - Release condition is evaluated each edge. If req[g]==0, or cnt==HOLD_MAX, then grant←0, ptr←(g+1) mod 8, and go to IDLE. Otherwise cnt←cnt+1.
  - tmo←1 for one cycle only when release is caused by cnt==HOLD_MAX while req[g] is still 1.
  - If both conditions hold on the same edge, it is a normal release: tmo=0.
- Datapath, every edge:
  - dout←din[sel] when state is BUSY; otherwise dout holds its value.
  - dout_valid←1 exactly when state is BUSY, else 0.
  - sel holds its last value while IDLE.
- Requests for other sources arriving during BUSY never preempt the grant.
- A force-released source that keeps req high is re-eligible, but only after the sources ahead of it in round-robin order.
- cnt width is 8 bits. cnt never exceeds HOLD_MAX and never wraps.
- ptr wraps 7→0.
- grant is always one-hot or zero.
- rst_n low at any time (mid-grant included) forces all outputs to reset values immediately; no pending grant survives.

## Timing
- req high at edge t while IDLE: grant visible after edge t (same cycle as busy).
- First valid word: dout=din[k] sampled at edge t+1, with dout_valid high after edge t+1 (1-cycle data latency after grant).
- Grant length equals the number of cycles req stays high after grant, capped at HOLD_MAX cycles.
- Release edge r: grant drops after r; dout_valid drops after r+1.
- At least one IDLE cycle occurs between consecutive grants, so the maximum bus utilisation is HOLD_MAX/(HOLD_MAX+1).
- Worst-case wait for a continuously requesting source is 7×(HOLD_MAX+1) cycles.

## Test plan
- Reset: hold rst_n=0 with req=8'hFF. Required: grant=0, sel=0, dout=0, dout_valid=0. Release reset: grant=8'h01 after the first edge.
- Single request: req=8'h08 for 3 cycles, then 0, with din3=32'hDEADBEEF. Required: grant=8'h08 for 3 cycles; dout=32'hDEADBEEF with dout_valid for 3 cycles, lagging grant by one; tmo never pulses.
- Round-robin: HOLD_MAX=4, req=8'h81 held constant. Required grant sequence 01,00,80,00,01,…, each non-zero grant lasting 4 cycles; tmo pulses at the end of every grant.
- Simultaneous release and timeout: HOLD_MAX=2, req[2] drops on the same edge cnt reaches 2. Required: grant released, tmo=0, ptr=3.
- Wrap-around priority: last grant to source 7, then req=8'h41. Required: next grant=8'h01 (ptr wrapped to 0).
- Reset mid-grant: rst_n pulsed low while grant=8'h20 and dout_valid=1. Required: grant, dout_valid, busy go to 0 immediately. After release with req=8'h20, grant=8'h20 resumes starting from ptr=0 search.

Source files
------------

// File: rtl/mux_arbiter8.sv
// Round-robin arbiter driving an 8:1 32-bit mux; grant registers on the request edge, data one edge later.
// No backpressure from the consumer; a grant is capped at HOLD_MAX cycles and a timeout is flagged on o_tmo.
module mux_arbiter8 #(
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_req,
   input  logic [31:0] i_din0,
   input  logic [31:0] i_din1,
   input  logic [31:0] i_din2,
   input  logic [31:0] i_din3,
   input  logic [31:0] i_din4,
   input  logic [31:0] i_din5,
   input  logic [31:0] i_din6,
   input  logic [31:0] i_din7,
   output logic [7:0]  o_grant,
   output logic [2:0]  o_sel,
   output logic [31:0] o_dout,
   output logic        o_dout_valid,
   output logic        o_tmo,
   output logic        o_busy
);

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_grant, w_grant_nxt;
   logic [2:0]  r_sel, w_sel_nxt;
   logic [2:0]  r_ptr, w_ptr_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic        r_tmo, w_tmo_nxt;
   logic [31:0] r_dout;
   logic        r_dout_valid;

   logic [31:0] w_din [8];
   logic [31:0] w_mux;
   logic [2:0]  w_pick;
   logic        w_any;
   logic        w_hold_req;
   logic        w_at_lim;

   assign w_din[0] = i_din0;
   assign w_din[1] = i_din1;
   assign w_din[2] = i_din2;
   assign w_din[3] = i_din3;
   assign w_din[4] = i_din4;
   assign w_din[5] = i_din5;
   assign w_din[6] = i_din6;
   assign w_din[7] = i_din7;
   assign w_mux    = w_din[r_sel];

   // Scan from the farthest offset down so the source nearest r_ptr wins.
   always_comb begin : pick
      logic [2:0] idx;
      w_pick = 3'd0;
      idx    = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         idx = r_ptr + 3'(i);
         if (i_req[idx]) w_pick = idx;
      end
   end

   assign w_any      = |i_req;
   assign w_hold_req = i_req[r_sel];
   assign w_at_lim   = (r_cnt == HOLD_LIM);

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_tmo_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_grant_nxt = 8'b1 << w_pick;
               w_sel_nxt   = w_pick;
               w_cnt_nxt   = 8'd1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!w_hold_req || w_at_lim) begin
               w_grant_nxt = 8'd0;
               w_ptr_nxt   = r_sel + 3'd1;
               w_cnt_nxt   = 8'd0;
               w_tmo_nxt   = w_at_lim && w_hold_req;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         default: begin
            w_grant_nxt = 8'd0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_grant      <= 8'd0;
         r_sel        <= 3'd0;
         r_ptr        <= 3'd0;
         r_cnt        <= 8'd0;
         r_tmo        <= 1'b0;
         r_dout       <= 32'd0;
         r_dout_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_sel        <= w_sel_nxt;
         r_ptr        <= w_ptr_nxt;
         r_cnt        <= w_cnt_nxt;
         r_tmo        <= w_tmo_nxt;
         r_dout_valid <= (r_state == S_BUSY);
         if (r_state == S_BUSY) r_dout <= w_mux;
      end
   end

   assign o_grant      = r_grant;
   assign o_sel        = r_sel;
   assign o_dout       = r_dout;
   assign o_dout_valid = r_dout_valid;
   assign o_tmo        = r_tmo;
   assign o_busy       = (r_state == S_BUSY);

endmodule
